// File: rtl/formula_nested_sqrt_fsm_if.sv
// Port bundle for formula_nested_sqrt_fsm: argument/result handshake on one side,
// request/response strobes to the shared isqrt unit on the other.
interface formula_nested_sqrt_fsm_if #(
    parameter int N_TERMS = 3,
    parameter int ARG_W   = 32
) ();
    logic                       arg_vld;
    logic                       arg_rdy;
    logic [N_TERMS*ARG_W-1:0]   args;
    logic                       res_vld;
    logic [ARG_W-1:0]           res;
    logic                       busy;
    logic                       spurious_y;
    logic                       isqrt_x_vld;
    logic [ARG_W-1:0]           isqrt_x;
    logic                       isqrt_y_vld;
    logic [ARG_W/2-1:0]         isqrt_y;

    modport slave (
        input  arg_vld, args, isqrt_y_vld, isqrt_y,
        output arg_rdy, res_vld, res, busy, spurious_y, isqrt_x_vld, isqrt_x
    );

    modport master (
        output arg_vld, args, isqrt_y_vld, isqrt_y,
        input  arg_rdy, res_vld, res, busy, spurious_y, isqrt_x_vld, isqrt_x
    );
endinterface

// File: rtl/formula_nested_sqrt_fsm.sv
// Nested root res = isqrt(arg[0] + isqrt(arg[1] + ... isqrt(arg[N_TERMS-1]))),
// evaluated innermost-first through one shared, latency-insensitive isqrt unit.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready for a new argument set (arg_rdy=1)
// S_ISSUE | one-cycle request to isqrt: arg[idx] + previous root
// S_WAIT  | waiting for the isqrt response of the current term
module formula_nested_sqrt_fsm #(
    parameter int N_TERMS = 3,
    parameter int ARG_W   = 32
) (
    input logic clk,
    input logic rst,
    formula_nested_sqrt_fsm_if.slave bus
);
    localparam int HALF_W = ARG_W / 2;
    localparam int IDX_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [ARG_W-1:0]   r_arg [N_TERMS];
    logic [HALF_W-1:0]  r_y;
    logic [ARG_W-1:0]   r_res;
    logic               r_res_vld;
    logic               r_busy;
    logic               r_spurious;

    logic               w_arg_rdy;
    logic               w_accept;
    logic               w_take;
    logic               w_last;
    logic               w_spur;
    logic               w_x_vld;
    logic [ARG_W-1:0]   w_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arg_rdy   = 1'b0;
        w_accept    = 1'b0;
        w_x_vld     = 1'b0;
        w_take      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_arg_rdy = 1'b1;
                if (bus.arg_vld) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_x_vld     = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.isqrt_y_vld) begin
                    w_take = 1'b1;
                    if (r_idx == '0) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A response is only meaningful while a request is outstanding.
    assign w_spur = bus.isqrt_y_vld & (r_state != S_WAIT);

    // r_y is cleared on accept, so the innermost call adds zero; the sum wraps.
    assign w_x = w_x_vld ? (r_arg[r_idx] + {{HALF_W{1'b0}}, r_y}) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= IDX_TOP;
            r_y        <= '0;
            r_res      <= '0;
            r_res_vld  <= 1'b0;
            r_busy     <= 1'b0;
            r_spurious <= 1'b0;
            for (int k = 0; k < N_TERMS; k++) begin
                r_arg[k] <= '0;
            end
        end else begin
            r_res_vld <= w_last;
            if (w_spur) begin
                r_spurious <= 1'b1;
            end
            if (w_accept) begin
                for (int k = 0; k < N_TERMS; k++) begin
                    r_arg[k] <= bus.args[k*ARG_W +: ARG_W];
                end
                r_idx  <= IDX_TOP;
                r_y    <= '0;
                r_busy <= 1'b1;
            end
            if (w_take) begin
                r_y <= bus.isqrt_y;
                if (w_last) begin
                    r_res  <= {{HALF_W{1'b0}}, bus.isqrt_y};
                    r_busy <= 1'b0;
                end else begin
                    r_idx <= r_idx - 1'b1;
                end
            end
        end
    end

    assign bus.arg_rdy     = w_arg_rdy;
    assign bus.res_vld     = r_res_vld;
    assign bus.res         = r_res;
    assign bus.busy        = r_busy;
    assign bus.spurious_y  = r_spurious;
    assign bus.isqrt_x_vld = w_x_vld;
    assign bus.isqrt_x     = w_x;
endmodule
